chip_bus_slave: RTL and testbench
=================================

# chip_bus_slave

Responder end of the chip_bus request/grant/ready protocol. Accepts single-beat read and write transactions from a bus master and services them from a small internal register-backed memory. Applies the bus even-parity `check` rule to write data, flags parity and address errors, and returns read data with generated parity. Sits on the slave side of the bus, opposite the CPU master.

## Interface
- `DEPTH`, 16: number of 64-bit words in the local store; power of two, 2..256.
- `BASE_ADDR`, 64'h0: first word address decoded by this slave.
- `WAIT_STATES`, 2: cycles inserted between grant and ready; 0..15.
- `clock`  in  1  rising-edge clock.
- `resetN`  in  1  asynchronous active-low reset.
- `request`  in  1  master transaction request.
- `rw`  in  1  1 = write, 0 = read; qualified by `request`.
- `address`  in  64  word address.
- `wdata`  in  64  write data.
- `wparity`  in  1  even-parity bit for `wdata`.
- `grant`  out  1  one-cycle acceptance pulse.
- `ready`  out  1  one-cycle completion pulse.
- `rdata`  out  64  read data, valid while `ready`=1.
- `rparity`  out  1  `^rdata`, valid while `ready`=1.
- `parity_err`  out  1  write parity failure, valid while `ready`=1.
- `addr_err`  out  1  address outside window, valid while `ready`=1.
- `err_count`  out  8  saturating count of parity errors.

## Operation
- FSM states: IDLE, GRANT, WAIT, RESP.
- IDLE: `request`=1 at an edge -> GRANT; same edge captures `rw`, `address`, `wdata`, `wparity` into holding registers. Otherwise stay.
- GRANT: `grant`=1 for exactly this state. Next: WAIT if `WAIT_STATES`>0, else RESP. Wait counter loaded with `WAIT_STATES`-1.
- WAIT: counter decrements each cycle; at 0 -> RESP.
- RESP: `ready`=1 for exactly this state; next -> IDLE unconditionally.
- Parity check: pass when `wparity == ^wdata` (captured values). Reads are never checked.
- Address decode: offset = address - BASE_ADDR (64-bit unsigned, wraps); in range when offset < DEPTH. Index = offset[log2(DEPTH)-1:0].
- Write commits on the GRANT->next edge only if in range and parity passes. Failed parity: no write, `parity_err`=1 in RESP, `err_count` +1 (saturates at 255). Out-of-range write: no write, `addr_err`=1; parity still checked and reported.
- Read: `rdata` = mem[index] registered on entry to RESP; out-of-range read returns 0 with `addr_err`=1. `rparity` = XOR of driven `rdata`.
- Outside RESP, `rdata`, `rparity`, `parity_err`, `addr_err` drive 0.
- Master deasserting `request` after grant does not abort; transaction completes. `request` held high after RESP starts a new transaction from IDLE (back-to-back spacing 1 idle cycle).

## Timing
- Reset (async assert, sync deassert at the master reset synchroniser): state IDLE; `grant`, `ready`, `rdata`, `rparity`, `parity_err`, `addr_err` = 0; `err_count` = 0; all memory words = 0; wait counter 0.
- Request sampled at edge k -> `grant` high cycle k+1 -> `ready` high cycle k+2+WAIT_STATES.
- Latency request-to-ready = 2+WAIT_STATES cycles; throughput one transaction per 3+WAIT_STATES cycles under continuous request.
- Write visible to a read whose grant occurs after the writing transaction's RESP.
- Reset mid-transaction: aborted immediately, no write commits if reset precedes the commit edge, no `ready` issued.
- `err_count` at 255 stays 255 on further parity errors.

## Test plan
- Reset: `resetN`=0 mid-WAIT -> all outputs 0, state IDLE, subsequent read of word 3 returns 0.
- Write addr 5 data 64'hDEAD_BEEF_0123_4567 good parity, then read addr 5 (WAIT_STATES=2) -> `grant` 1 cycle after request, `ready` 4 cycles after request, `rdata` matches, `rparity`=^data, no errors.
- Write addr 2 with inverted parity -> `parity_err`=1 on ready, `err_count`=1, read addr 2 returns prior 0.
- Read addr BASE_ADDR+DEPTH and write addr 64'hFFFF_FFFF_FFFF_FFFF (BASE_ADDR=0) -> `addr_err`=1, read `rdata`=0, no memory change.
- Continuous `request`=1 for 4 transactions -> `grant` pulses every 5 cycles (WAIT_STATES=2), `request` dropped after grant still yields `ready`.
- 260 bad-parity writes -> `err_count` saturates at 255; WAIT_STATES=0 build: ready 2 cycles after request.

Source files
------------

// File: rtl/chip_bus_slave_if.sv
// chip_bus_slave_if: request/grant/ready bus between a master and a chip_bus slave.
//   master modport : drives request, rw, address, wdata, wparity; observes the response.
//   slave modport  : observes the request fields; drives grant, ready, rdata, rparity,
//                    parity_err, addr_err and err_count.
interface chip_bus_slave_if;
   logic        request;
   logic        rw;
   logic [63:0] address;
   logic [63:0] wdata;
   logic        wparity;
   logic        grant;
   logic        ready;
   logic [63:0] rdata;
   logic        rparity;
   logic        parity_err;
   logic        addr_err;
   logic [7:0]  err_count;

   modport master (
      output request, rw, address, wdata, wparity,
      input  grant, ready, rdata, rparity, parity_err, addr_err, err_count
   );

   modport slave (
      input  request, rw, address, wdata, wparity,
      output grant, ready, rdata, rparity, parity_err, addr_err, err_count
   );
endinterface

// File: rtl/chip_bus_slave.sv
// chip_bus_slave: responder for single-beat chip_bus reads/writes backed by a local
// DEPTH x 64-bit register store. Write data is even-parity checked, out-of-window
// addresses are flagged, and read data is returned with generated parity.
//   clock  : rising-edge clock
//   resetN : asynchronous active-low reset
//   bus    : chip_bus_slave_if.slave (request fields in, grant/ready/response out)
module chip_bus_slave #(
   parameter int unsigned DEPTH       = 16,
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter int unsigned WAIT_STATES = 2
) (
   input logic             clock,
   input logic             resetN,
   chip_bus_slave_if.slave bus
);

   localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {StIdle, StGrant, StWait, StResp} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;

   // Request fields held for the whole transaction; the master may change them after grant.
   logic        rw_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic        wparity_q;

   logic [63:0] mem_q [DEPTH];
   logic [63:0] rdata_q;
   logic        perr_q;
   logic        aerr_q;
   logic [7:0]  err_count_q;

   logic [63:0]     offset;
   logic            in_range;
   logic [IdxW-1:0] idx;
   logic            parity_ok;
   logic            commit;
   logic            bad_write;
   logic            resp;

   // Offset wraps modulo 2^64, so addresses below BASE_ADDR land far out of range.
   assign offset    = addr_q - BASE_ADDR;
   assign in_range  = offset < 64'(DEPTH);
   assign idx       = offset[IdxW-1:0];
   assign parity_ok = (wparity_q == ^wdata_q);
   assign commit    = (state_q == StGrant) && rw_q && parity_ok && in_range;
   assign bad_write = (state_q == StGrant) && rw_q && !parity_ok;
   assign resp      = (state_q == StResp);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (bus.request) state_d = StGrant;
         end
         StGrant: begin
            if (WAIT_STATES > 0) begin
               state_d = StWait;
               cnt_d   = 4'(WAIT_STATES - 1);
            end else begin
               state_d = StResp;
            end
         end
         StWait: begin
            if (cnt_q == 4'd0) state_d = StResp;
            else               cnt_d   = cnt_q - 4'd1;
         end
         StResp: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         rw_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wparity_q   <= 1'b0;
         rdata_q     <= '0;
         perr_q      <= 1'b0;
         aerr_q      <= 1'b0;
         err_count_q <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == StIdle && bus.request) begin
            rw_q      <= bus.rw;
            addr_q    <= bus.address;
            wdata_q   <= bus.wdata;
            wparity_q <= bus.wparity;
         end
         // Response is latched on entry to RESP, after any write of this transaction.
         if (state_d == StResp) begin
            rdata_q <= (!rw_q && in_range) ? mem_q[idx] : '0;
            perr_q  <= rw_q && !parity_ok;
            aerr_q  <= !in_range;
         end
         if (bad_write && err_count_q != 8'hFF) begin
            err_count_q <= err_count_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else if (commit) begin
         mem_q[idx] <= wdata_q;
      end
   end

   assign bus.grant      = (state_q == StGrant);
   assign bus.ready      = resp;
   assign bus.rdata      = resp ? rdata_q : '0;
   assign bus.rparity    = resp & (^rdata_q);
   assign bus.parity_err = resp & perr_q;
   assign bus.addr_err   = resp & aerr_q;
   assign bus.err_count  = err_count_q;

endmodule

// File: tb/tb_chip_bus_slave.sv
// tb_chip_bus_slave: self-checking bench for chip_bus_slave. Two instances are exercised:
// u2 (DEPTH 16, base 0, two wait states) and u0 (DEPTH 8, base 0x40, no wait states).
module tb_chip_bus_slave;

   localparam int unsigned D2 = 16;
   localparam int unsigned D0 = 8;
   localparam logic [63:0] B2 = 64'h0;
   localparam logic [63:0] B0 = 64'h40;

   logic clock = 1'b0;
   logic resetN = 1'b0;
   always #5 clock = ~clock;

   chip_bus_slave_if bus2 ();
   chip_bus_slave_if bus0 ();

   chip_bus_slave #(.DEPTH(D2), .BASE_ADDR(B2), .WAIT_STATES(2)) u2 (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus2)
   );

   chip_bus_slave #(.DEPTH(D0), .BASE_ADDR(B0), .WAIT_STATES(0)) u0 (
      .clock (clock),
      .resetN(resetN),
      .bus   (bus0)
   );

   int tests_run = 0;
   int tests_failed = 0;

   // Reference store and error counters.
   logic [63:0] m2 [D2];
   logic [63:0] m0 [D0];
   int ec2, ec0;

   // Observed transaction results.
   int          o_glat, o_rlat, o_ngrant;
   logic [63:0] o_rd;
   logic        o_rp, o_pe, o_ae;
   logic [7:0]  o_ec;
   bit          o_dirty;

   // Expected transaction results.
   logic [63:0] e_rd;
   logic        e_pe, e_ae;
   int          e_ec;

   task automatic model_reset();
      for (int i = 0; i < int'(D2); i++) m2[i] = '0;
      for (int i = 0; i < int'(D0); i++) m0[i] = '0;
      ec2 = 0;
      ec0 = 0;
   endtask

   task automatic model_txn(input bit sel, input logic rw, input logic [63:0] a,
                            input logic [63:0] d, input logic p);
      logic [63:0] off;
      int          depth;
      depth = sel ? int'(D0) : int'(D2);
      off   = a - (sel ? B0 : B2);
      e_ae  = !(off < 64'(depth));
      e_pe  = rw && (p != ^d);
      e_rd  = '0;
      if (!rw && !e_ae) e_rd = sel ? m0[int'(off)] : m2[int'(off)];
      if (rw && !e_pe && !e_ae) begin
         if (sel) m0[int'(off)] = d;
         else     m2[int'(off)] = d;
      end
      if (e_pe) begin
         if (sel) ec0 = (ec0 < 255) ? ec0 + 1 : 255;
         else     ec2 = (ec2 < 255) ? ec2 + 1 : 255;
      end
      e_ec = sel ? ec0 : ec2;
   endtask

   task automatic drive(input bit sel, input logic req, input logic rw, input logic [63:0] a,
                        input logic [63:0] d, input logic p);
      if (sel) begin
         bus0.request = req; bus0.rw = rw; bus0.address = a; bus0.wdata = d; bus0.wparity = p;
      end else begin
         bus2.request = req; bus2.rw = rw; bus2.address = a; bus2.wdata = d; bus2.wparity = p;
      end
   endtask

   // One transaction; request dropped (and fields scrambled) as soon as grant is seen.
   task automatic run_txn(input bit sel, input logic rw, input logic [63:0] a,
                          input logic [63:0] d, input logic p);
      logic g, r, busy;
      o_glat = -1; o_rlat = -1; o_ngrant = 0; o_dirty = 0;
      o_rd = '0; o_rp = 0; o_pe = 0; o_ae = 0; o_ec = '0;
      @(posedge clock); #1;
      drive(sel, 1'b1, rw, a, d, p);
      for (int c = 1; c <= 40; c++) begin
         @(posedge clock); #1;
         g = sel ? bus0.grant : bus2.grant;
         r = sel ? bus0.ready : bus2.ready;
         if (g) begin
            o_ngrant++;
            if (o_glat < 0) o_glat = c;
            drive(sel, 1'b0, ~rw, {$urandom, $urandom}, {$urandom, $urandom}, ~p);
         end
         if (r) begin
            o_rlat = c;
            o_rd = sel ? bus0.rdata : bus2.rdata;
            o_rp = sel ? bus0.rparity : bus2.rparity;
            o_pe = sel ? bus0.parity_err : bus2.parity_err;
            o_ae = sel ? bus0.addr_err : bus2.addr_err;
            o_ec = sel ? bus0.err_count : bus2.err_count;
            break;
         end
         busy = sel ? |{bus0.rdata, bus0.rparity, bus0.parity_err, bus0.addr_err}
                    : |{bus2.rdata, bus2.rparity, bus2.parity_err, bus2.addr_err};
         if (busy) o_dirty = 1;
      end
      drive(sel, 1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic test_reset();
      logic [63:0] d;
      logic        seen;
      d = 64'hA5A5_0000_FFFF_1234;
      run_txn(0, 1'b1, 64'd3, d, ~^d);
      model_txn(0, 1'b1, 64'd3, d, ~^d);
      run_txn(0, 1'b1, 64'd3, d, ^d);
      model_txn(0, 1'b1, 64'd3, d, ^d);
      run_txn(0, 1'b0, 64'd3, '0, 1'b0);
      model_txn(0, 1'b0, 64'd3, '0, 1'b0);
      tests_run++;
      if (o_rd !== e_rd) begin
         tests_failed++; $display("FAIL reset_pre_read: got %h expected %h", o_rd, e_rd);
      end
      // Abort a read in the WAIT phase.
      @(posedge clock); #1;
      drive(0, 1'b1, 1'b0, 64'd3, '0, 1'b0);
      @(posedge clock); #1;
      drive(0, 1'b0, 1'b0, 64'd3, '0, 1'b0);
      @(posedge clock); #2;
      resetN = 1'b0;
      #1;
      tests_run++;
      if ({bus2.grant, bus2.ready, bus2.rdata, bus2.rparity, bus2.parity_err, bus2.addr_err}
          !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got g%b r%b d%h p%b pe%b ae%b expected all 0",
                  bus2.grant, bus2.ready, bus2.rdata, bus2.rparity, bus2.parity_err,
                  bus2.addr_err);
      end
      tests_run++;
      if (bus2.err_count !== 8'd0) begin
         tests_failed++; $display("FAIL reset_err_count: got %0d expected 0", bus2.err_count);
      end
      @(posedge clock); @(posedge clock); #1;
      resetN = 1'b1;
      model_reset();
      seen = 1'b0;
      repeat (4) begin
         @(posedge clock); #1;
         if (bus2.ready || bus2.grant) seen = 1'b1;
      end
      tests_run++;
      if (seen !== 1'b0) begin
         tests_failed++; $display("FAIL reset_no_ready: got activity %b expected 0", seen);
      end
      run_txn(0, 1'b0, 64'd3, '0, 1'b0);
      model_txn(0, 1'b0, 64'd3, '0, 1'b0);
      tests_run++;
      if (o_rd !== e_rd) begin
         tests_failed++; $display("FAIL reset_read3: got %h expected %h", o_rd, e_rd);
      end
   endtask

   task automatic test_write_read();
      logic [63:0] d;
      d = 64'hDEAD_BEEF_0123_4567;
      run_txn(0, 1'b1, 64'd5, d, ^d);
      model_txn(0, 1'b1, 64'd5, d, ^d);
      tests_run++;
      if (o_glat != 1 || o_rlat != 4 || o_pe !== 1'b0 || o_ae !== 1'b0) begin
         tests_failed++;
         $display("FAIL wr_write: got glat %0d rlat %0d pe %b ae %b expected 1 4 0 0",
                  o_glat, o_rlat, o_pe, o_ae);
      end
      run_txn(0, 1'b0, 64'd5, '0, 1'b0);
      model_txn(0, 1'b0, 64'd5, '0, 1'b0);
      tests_run++;
      if (o_glat != 1 || o_rlat != 4) begin
         tests_failed++;
         $display("FAIL wr_read_latency: got %0d/%0d expected 1/4", o_glat, o_rlat);
      end
      tests_run++;
      if (o_rd !== e_rd || o_rp !== ^e_rd) begin
         tests_failed++;
         $display("FAIL wr_read_data: got %h p%b expected %h p%b", o_rd, o_rp, e_rd, ^e_rd);
      end
      tests_run++;
      if (o_pe !== 1'b0 || o_ae !== 1'b0 || o_dirty) begin
         tests_failed++;
         $display("FAIL wr_read_flags: got pe%b ae%b dirty%b expected 0 0 0",
                  o_pe, o_ae, o_dirty);
      end
   endtask

   task automatic test_parity();
      logic [63:0] d;
      d = {$urandom, $urandom};
      run_txn(0, 1'b1, 64'd2, d, ~^d);
      model_txn(0, 1'b1, 64'd2, d, ~^d);
      tests_run++;
      if (o_pe !== 1'b1 || o_ae !== 1'b0) begin
         tests_failed++; $display("FAIL parity_flag: got pe%b ae%b expected 1 0", o_pe, o_ae);
      end
      tests_run++;
      if (o_ec !== 8'(e_ec)) begin
         tests_failed++; $display("FAIL parity_count: got %0d expected %0d", o_ec, e_ec);
      end
      run_txn(0, 1'b0, 64'd2, '0, 1'b0);
      model_txn(0, 1'b0, 64'd2, '0, 1'b0);
      tests_run++;
      if (o_rd !== e_rd) begin
         tests_failed++; $display("FAIL parity_nowrite: got %h expected %h", o_rd, e_rd);
      end
   endtask

   task automatic test_addr_err();
      logic [63:0] d;
      run_txn(0, 1'b0, B2 + 64'(D2), '0, 1'b0);
      model_txn(0, 1'b0, B2 + 64'(D2), '0, 1'b0);
      tests_run++;
      if (o_ae !== 1'b1 || o_rd !== 64'd0 || o_rp !== 1'b0) begin
         tests_failed++;
         $display("FAIL addr_read: got ae%b d%h p%b expected 1 0 0", o_ae, o_rd, o_rp);
      end
      d = {$urandom, $urandom} | 64'h1;
      run_txn(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, d, ^d);
      model_txn(0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, d, ^d);
      tests_run++;
      if (o_ae !== 1'b1 || o_pe !== 1'b0) begin
         tests_failed++; $display("FAIL addr_write: got ae%b pe%b expected 1 0", o_ae, o_pe);
      end
      for (int i = 0; i < int'(D2); i++) begin
         run_txn(0, 1'b0, 64'(i), '0, 1'b0);
         model_txn(0, 1'b0, 64'(i), '0, 1'b0);
         tests_run++;
         if (o_rd !== e_rd) begin
            tests_failed++;
            $display("FAIL addr_nochange[%0d]: got %h expected %h", i, o_rd, e_rd);
         end
      end
   endtask

   task automatic test_back_to_back();
      int gt[4];
      int rt[4];
      int ng, nr;
      ng = 0; nr = 0;
      for (int i = 0; i < 4; i++) begin gt[i] = -1; rt[i] = -1; end
      model_txn(0, 1'b0, 64'd5, '0, 1'b0);
      @(posedge clock); #1;
      drive(0, 1'b1, 1'b0, 64'd5, '0, 1'b0);
      for (int c = 1; c <= 40 && nr < 4; c++) begin
         @(posedge clock); #1;
         if (bus2.grant) begin
            if (ng < 4) gt[ng] = c;
            ng++;
            if (ng == 4) drive(0, 1'b0, 1'b0, 64'd5, '0, 1'b0);
         end
         if (bus2.ready) begin
            if (nr < 4) rt[nr] = c;
            nr++;
            tests_run++;
            if (bus2.rdata !== e_rd) begin
               tests_failed++;
               $display("FAIL b2b_data: got %h expected %h", bus2.rdata, e_rd);
            end
         end
      end
      drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
      tests_run++;
      if (ng != 4 || nr != 4) begin
         tests_failed++; $display("FAIL b2b_count: got %0d/%0d expected 4/4", ng, nr);
      end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (gt[i] != 1 + 5 * i || rt[i] != 4 + 5 * i) begin
            tests_failed++;
            $display("FAIL b2b_timing[%0d]: got g%0d r%0d expected g%0d r%0d",
                     i, gt[i], rt[i], 1 + 5 * i, 4 + 5 * i);
         end
      end
   endtask

   task automatic test_random();
      bit          sel;
      logic        rw, p;
      logic [63:0] a, d, base;
      int          depth;
      for (int n = 0; n < 80; n++) begin
         sel   = 1'($urandom_range(0, 1));
         base  = sel ? B0 : B2;
         depth = sel ? int'(D0) : int'(D2);
         rw    = 1'($urandom_range(0, 1));
         d     = {$urandom, $urandom};
         p     = ($urandom_range(0, 4) == 0) ? ~^d : ^d;
         case ($urandom_range(0, 9))
            0:       a = {$urandom, $urandom};
            1:       a = base - 64'd1;
            default: a = base + 64'($urandom_range(0, depth + 1));
         endcase
         run_txn(sel, rw, a, d, p);
         model_txn(sel, rw, a, d, p);
         tests_run++;
         if (o_ngrant != 1 || o_glat != 1 || o_rlat != (sel ? 2 : 4) || o_dirty) begin
            tests_failed++;
            $display("FAIL rand_timing: got n%0d g%0d r%0d dirty%b expected 1 1 %0d 0",
                     o_ngrant, o_glat, o_rlat, o_dirty, sel ? 2 : 4);
         end
         tests_run++;
         if (o_rd !== e_rd || o_rp !== ^e_rd || o_pe !== e_pe || o_ae !== e_ae) begin
            tests_failed++;
            $display("FAIL rand_resp: got %h p%b pe%b ae%b expected %h p%b pe%b ae%b",
                     o_rd, o_rp, o_pe, o_ae, e_rd, ^e_rd, e_pe, e_ae);
         end
         tests_run++;
         if (o_ec !== 8'(e_ec)) begin
            tests_failed++; $display("FAIL rand_err_count: got %0d expected %0d", o_ec, e_ec);
         end
      end
   endtask

   task automatic test_zero_wait();
      logic [63:0] d;
      d = {$urandom, $urandom};
      run_txn(1, 1'b1, B0 + 64'd6, d, ^d);
      model_txn(1, 1'b1, B0 + 64'd6, d, ^d);
      run_txn(1, 1'b0, B0 + 64'd6, '0, 1'b0);
      model_txn(1, 1'b0, B0 + 64'd6, '0, 1'b0);
      tests_run++;
      if (o_glat != 1 || o_rlat != 2 || o_rd !== e_rd) begin
         tests_failed++;
         $display("FAIL zero_wait: got g%0d r%0d %h expected g1 r2 %h",
                  o_glat, o_rlat, o_rd, e_rd);
      end
   endtask

   task automatic test_saturate();
      logic [63:0] d;
      logic [63:0] a;
      for (int n = 0; n < 260; n++) begin
         d = {$urandom, $urandom};
         a = B0 + 64'($urandom_range(0, int'(D0) - 1));
         run_txn(1, 1'b1, a, d, ~^d);
         model_txn(1, 1'b1, a, d, ~^d);
         tests_run++;
         if (o_ec !== 8'(e_ec) || o_pe !== 1'b1) begin
            tests_failed++;
            $display("FAIL sat_step[%0d]: got %0d pe%b expected %0d pe1", n, o_ec, o_pe, e_ec);
         end
      end
      tests_run++;
      if (bus0.err_count !== 8'd255) begin
         tests_failed++; $display("FAIL sat_final: got %0d expected 255", bus0.err_count);
      end
   endtask

   initial begin
      drive(0, 1'b0, 1'b0, '0, '0, 1'b0);
      drive(1, 1'b0, 1'b0, '0, '0, 1'b0);
      resetN = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      resetN = 1'b1;
      model_reset();
      test_reset();
      test_write_read();
      test_parity();
      test_addr_err();
      test_back_to_back();
      test_zero_wait();
      test_random();
      test_saturate();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
